bin_video_src: RTL and testbench
================================

// Module: bin_video_src
// PURPOSE
//  Binary video stream source: generates frame timing (vsync/href/clken) and a 1-bit pixel
//  per clken in the exact format consumed by the 3x3 morphology blocks (dilation/erosion).
//  Used as the upstream driver in simulation and as an on-chip pattern source for bring-up.
//  It produces the post_* stream that downstream per_* inputs connect to directly.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line (clken pulses per href)
//  V_ACTIVE   480  active lines per frame
//  H_BLANK    16   cycles with href low after each line
//  V_FRONT    2    blank lines (vsync high, href low) before first active line
//  V_GAP      32   cycles with vsync low between frames
//  CLKEN_DIV  1    clk cycles per pixel (>=1); clken high on first cycle of each group
//  DOT_X      320  column of the single dot in pattern 1
//  DOT_Y      240  row of the single dot in pattern 1
// PORTS
//  clk               in   1  pixel clock
//  rst               in   1  reset; synchronous, active-high
//  enable            in   1  start/continue frame generation
//  pattern_sel       in   2  0 all-zero, 1 single dot, 2 checkerboard x^y, 3 stripes x[3]
//  post_frame_vsync  out  1  high for the whole frame (front lines + active lines)
//  post_frame_href   out  1  high during active pixels of an active line
//  post_frame_clken  out  1  pixel-valid strobe, only while href high
//  post_img_Bit      out  1  pixel value; forced 0 when href low
//  frame_done        out  1  one-cycle pulse on the cycle vsync falls
// BEHAVIOUR
//  - All outputs registered; reset (rst=1 at clk edge) -> all outputs 0, FSM IDLE,
//    counters 0. Reset mid-frame aborts the frame; no frame_done emitted.
//  - FSM: IDLE -> FRONT -> ACTIVE <-> HBLANK -> GAP -> (FRONT | IDLE).
//  - IDLE: outputs 0. enable=1 sampled at edge N -> vsync=1 from N+1; pattern_sel latched
//    at that edge; changes mid-frame ignored until next frame start.
//  - Line length L = H_ACTIVE*CLKEN_DIV + H_BLANK cycles for every line, front or active.
//  - FRONT: V_FRONT lines of L cycles, href=0. V_FRONT=0 -> go straight to ACTIVE.
//  - ACTIVE: href=1 for H_ACTIVE*CLKEN_DIV cycles; clken=1 on cycle 0 of each
//    CLKEN_DIV group (CLKEN_DIV=1 -> clken=href). x increments after each clken.
//  - HBLANK: H_BLANK cycles href=0; then y++ and back to ACTIVE, or after line
//    V_ACTIVE-1 drop vsync, pulse frame_done, enter GAP. H_BLANK=0 -> href stays high
//    across lines (back-to-back lines); clken cadence uninterrupted.
//  - GAP: V_GAP cycles with vsync=0; then FRONT if enable=1 else IDLE.
//    enable deasserted mid-frame: current frame always completes.
//  - Pixel value per clken at (x,y), x in [0,H_ACTIVE), y in [0,V_ACTIVE):
//    p0 = 0; p1 = (x==DOT_X && y==DOT_Y); p2 = x[0]^y[0]; p3 = x[3].
//    Bit value holds between clkens within href; 0 whenever href=0.
//  - Counters 12-bit; x wraps to 0 at end of line, y to 0 at frame end. Parameters
//    beyond 4095 are illegal.
//  - vsync, href, clken, Bit change on the same edge (mutually aligned, zero skew).
// TESTING  (bench params: H_ACTIVE=8 V_ACTIVE=4 H_BLANK=3 V_FRONT=1 V_GAP=5 CLKEN_DIV=2)
//  1 rst held 3 cycles mid-frame -> cycle after rst all outputs 0, no frame_done; restart OK.
//  2 enable 1-cycle pulse, sel=2 -> vsync high 95 cycles, 4 href pulses of 16 cycles,
//    32 clkens, Bit = x^y checker, single frame_done, then IDLE.
//  3 sel=1, DOT=(3,2) -> exactly one clken with Bit=1, on 4th clken of 3rd active line.
//  4 sel changed 2->3 mid-frame -> current frame stays checker; next frame shows stripes.
//  5 enable held high -> consecutive frames, vsync low exactly 5 cycles between them.
//  6 CLKEN_DIV=1, H_BLANK=0 -> href continuous 32 cycles, clken==href, count=32.

Source files
------------

// File: rtl/bin_video_src.sv
// ---------------------------------------------------------------------------
// bin_video_src
//   Binary video stream source. It generates frame timing (vsync, href,
//   clken) and one pixel bit per clken. The post_* stream uses the format
//   that the 3x3 morphology blocks take on their per_* inputs.
//
//   Frame sequence: IDLE -> FRONT -> ACTIVE <-> HBLANK -> GAP -> FRONT|IDLE.
//   Every line, front or active, lasts H_ACTIVE*CLKEN_DIV + H_BLANK cycles.
//
// Ports
//   clk               in   pixel clock
//   rst               in   synchronous, active-high reset
//   enable            in   start or continue frame generation
//   pattern_sel[1:0]  in   0 zero, 1 single dot, 2 checker x^y, 3 stripes x[3]
//   post_frame_vsync  out  high for the whole frame (front + active lines)
//   post_frame_href   out  high during the active pixels of a line
//   post_frame_clken  out  pixel-valid strobe, only while href is high
//   post_img_Bit      out  pixel value, 0 whenever href is low
//   frame_done        out  one-cycle pulse on the cycle vsync falls
// ---------------------------------------------------------------------------
module bin_video_src #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 16,
    parameter int V_FRONT   = 2,
    parameter int V_GAP     = 32,
    parameter int CLKEN_DIV = 1,
    parameter int DOT_X     = 320,
    parameter int DOT_Y     = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit,
    output logic       frame_done
);

    localparam int ACT_LEN  = H_ACTIVE * CLKEN_DIV;
    localparam int LINE_LEN = ACT_LEN + H_BLANK;
    // vsync must fall for at least one cycle so that frame_done has a home.
    localparam int GAP_LEN  = (V_GAP < 1) ? 1 : V_GAP;

    // Terminal counts. A terminal count whose state can never be entered
    // (for example HB_LAST when H_BLANK=0) wraps to all-ones and is never used.
    localparam logic [15:0] ACT_LAST   = 16'(ACT_LEN - 1);
    localparam logic [15:0] LINE_LAST  = 16'(LINE_LEN - 1);
    localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_LEN - 1);
    localparam logic [11:0] DIV_LAST   = 12'(CLKEN_DIV - 1);
    localparam logic [11:0] FRONT_LAST = 12'(V_FRONT - 1);
    localparam logic [11:0] Y_LAST     = 12'(V_ACTIVE - 1);
    localparam logic [11:0] DOT_X12    = 12'(DOT_X);
    localparam logic [11:0] DOT_Y12    = 12'(DOT_Y);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_ACTIVE,
        S_HBLANK,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;     // cycle within the current phase
    logic [11:0] r_line;    // front-porch line index
    logic [11:0] r_div;     // position inside a CLKEN_DIV group
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [1:0]  r_sel;     // pattern frozen for the current frame
    logic        r_vsync;
    logic        r_href;
    logic        r_clken;
    logic        r_bit;
    logic        r_done;

    function automatic logic pixel(input logic [1:0]  sel,
                                   input logic [11:0] x,
                                   input logic [11:0] y);
        case (sel)
            2'd0:    return 1'b0;
            2'd1:    return (x == DOT_X12) && (y == DOT_Y12);
            2'd2:    return x[0] ^ y[0];
            default: return x[3];
        endcase
    endfunction

    logic        w_frame_start;
    logic        w_act_last;
    logic        w_line_end;
    logic        w_last_line;
    logic        w_front_done;
    logic        w_frame_end;
    logic        w_line_start;
    logic [11:0] w_start_y;
    logic [1:0]  w_sel;
    logic [11:0] w_next_x;
    logic        w_start_bit;

    // A new frame starts from IDLE, or back-to-back at the end of GAP.
    assign w_frame_start = enable &&
                           ((r_state == S_IDLE) ||
                            ((r_state == S_GAP) && (r_cnt == GAP_LAST)));
    assign w_act_last    = (r_state == S_ACTIVE) && (r_cnt == ACT_LAST);
    // With no horizontal blanking the line ends on its last active cycle, so
    // href stays high straight into the next line.
    assign w_line_end    = ((r_state == S_HBLANK) && (r_cnt == HB_LAST)) ||
                           (w_act_last && (H_BLANK == 0));
    assign w_last_line   = (r_y == Y_LAST);
    assign w_front_done  = (r_state == S_FRONT) && (r_cnt == LINE_LAST) &&
                           (r_line == FRONT_LAST);
    assign w_frame_end   = w_line_end && w_last_line;
    assign w_line_start  = w_front_done || (w_line_end && !w_last_line) ||
                           (w_frame_start && (V_FRONT == 0));
    assign w_start_y     = w_line_end ? r_y + 12'd1 : 12'd0;
    // At a frame start the first pixel must already use the new pattern.
    assign w_sel         = w_frame_start ? pattern_sel : r_sel;
    assign w_next_x      = r_x + 12'd1;
    assign w_start_bit   = pixel(w_sel, 12'd0, w_start_y);

    // NOTE: state and outputs are updated with non-blocking assignments, so
    // every branch reads the pre-edge values and all outputs move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_div   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sel   <= '0;
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_clken <= 1'b0;
            r_bit   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_frame_start) begin
                r_sel <= pattern_sel;
            end

            if (w_line_start) begin
                r_state <= S_ACTIVE;
                r_cnt   <= '0;
                r_div   <= '0;
                r_line  <= '0;
                r_x     <= '0;
                r_y     <= w_start_y;
                r_vsync <= 1'b1;
                r_href  <= 1'b1;
                r_clken <= 1'b1;
                r_bit   <= w_start_bit;
            end else if (w_frame_end) begin
                r_state <= S_GAP;
                r_cnt   <= '0;
                r_x     <= '0;
                r_y     <= '0;
                r_vsync <= 1'b0;
                r_href  <= 1'b0;
                r_clken <= 1'b0;
                r_bit   <= 1'b0;
                r_done  <= 1'b1;
            end else if (w_frame_start) begin
                // Only reached when there are front-porch lines.
                r_state <= S_FRONT;
                r_cnt   <= '0;
                r_line  <= '0;
                r_vsync <= 1'b1;
                r_href  <= 1'b0;
                r_clken <= 1'b0;
                r_bit   <= 1'b0;
            end else begin
                case (r_state)
                    S_FRONT: begin
                        if (r_cnt == LINE_LAST) begin
                            r_cnt  <= '0;
                            r_line <= r_line + 12'd1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    S_ACTIVE: begin
                        if (w_act_last) begin
                            r_state <= S_HBLANK;
                            r_cnt   <= '0;
                            r_x     <= '0;
                            r_href  <= 1'b0;
                            r_clken <= 1'b0;
                            r_bit   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                            if (r_div == DIV_LAST) begin
                                r_div   <= '0;
                                r_x     <= w_next_x;
                                r_clken <= 1'b1;
                                r_bit   <= pixel(r_sel, w_next_x, r_y);
                            end else begin
                                // Bit holds until the next clken.
                                r_div   <= r_div + 12'd1;
                                r_clken <= 1'b0;
                            end
                        end
                    end
                    S_HBLANK: begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    S_GAP: begin
                        if (r_cnt == GAP_LAST) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign post_frame_vsync = r_vsync;
    assign post_frame_href  = r_href;
    assign post_frame_clken = r_clken;
    assign post_img_Bit     = r_bit;
    assign frame_done       = r_done;

endmodule

// File: tb/tb_bin_video_src.sv
// ---------------------------------------------------------------------------
// tb_bin_video_src
//   Drives two bin_video_src instances from shared inputs:
//     A: H_ACTIVE=8 V_ACTIVE=4 H_BLANK=3 V_FRONT=1 V_GAP=5 CLKEN_DIV=2, dot (3,2)
//     B: as A but H_BLANK=0 and CLKEN_DIV=1 (back-to-back lines)
//   A timeline model gives the expected outputs for every cycle. The outputs
//   are queued when the inputs are driven and compared after the clock edge.
//   Frame-level counts are then checked against fixed expected values.
// ---------------------------------------------------------------------------
module tb_bin_video_src;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] sel;

    logic a_vs, a_hr, a_ce, a_px, a_fd;
    logic b_vs, b_hr, b_ce, b_px, b_fd;

    always #5 clk = ~clk;

    bin_video_src #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(3), .V_FRONT(1),
        .V_GAP(5), .CLKEN_DIV(2), .DOT_X(3), .DOT_Y(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(sel),
        .post_frame_vsync(a_vs), .post_frame_href(a_hr),
        .post_frame_clken(a_ce), .post_img_Bit(a_px), .frame_done(a_fd)
    );

    bin_video_src #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(0), .V_FRONT(1),
        .V_GAP(5), .CLKEN_DIV(1), .DOT_X(3), .DOT_Y(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(sel),
        .post_frame_vsync(b_vs), .post_frame_href(b_hr),
        .post_frame_clken(b_ce), .post_img_Bit(b_px), .frame_done(b_fd)
    );

    // Model state. mode: 0 idle, 1 in frame (t = cycle of frame), 2 gap.
    typedef struct {
        int         mode;
        int         t;
        int         g;
        logic [1:0] sel;
    } mstate_t;

    typedef struct {
        logic       r;
        logic       en;
        logic [1:0] sl;
        int         n;
    } vec_t;

    mstate_t    ma, mb;
    logic [4:0] q_a[$];
    logic [4:0] q_b[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;

    // Window statistics. Prev values persist between windows.
    int   s_vs_a, s_hrise_a, s_ce_a, s_fd_a, s_dot_a, s_dot_idx, s_vrise_a;
    int   s_ce_b, s_hr_b, s_run_b, s_maxrun_b, s_ne_b, s_fd_b;
    int   low_run;
    bit   seen_fall;
    int   gaps[$];
    logic p_hr_a = 1'b0;
    logic p_vs_a = 1'b0;

    function automatic logic m_pix(input logic [1:0] s, input int x, input int y);
        case (s)
            2'd0:    return 1'b0;
            2'd1:    return (x == 3) && (y == 2);
            2'd2:    return ((x ^ y) & 1) != 0;
            default: return ((x >> 3) & 1) != 0;
        endcase
    endfunction

    function automatic mstate_t m_next(input mstate_t s, input logic r, input logic en,
                                       input logic [1:0] sl, input int frame_len,
                                       input int gap_len);
        mstate_t n = s;
        if (r) begin
            n.mode = 0; n.t = 0; n.g = 0;
        end else begin
            case (s.mode)
                0: if (en) begin n.mode = 1; n.t = 0; n.sel = sl; end
                1: begin
                    n.t = s.t + 1;
                    if (n.t == frame_len) begin n.mode = 2; n.g = 0; end
                end
                default: begin
                    n.g = s.g + 1;
                    if (n.g == gap_len) begin
                        if (en) begin n.mode = 1; n.t = 0; n.sel = sl; end
                        else n.mode = 0;
                    end
                end
            endcase
        end
        return n;
    endfunction

    // Returns {vsync, href, clken, bit, frame_done}.
    function automatic logic [4:0] m_out(input mstate_t s, input int ha, input int hb,
                                         input int vf, input int dv);
        int l = ha * dv + hb;
        int front = vf * l;
        int u, pos;
        logic [4:0] o = 5'b0;
        if (s.mode == 1) begin
            o[4] = 1'b1;
            if (s.t >= front) begin
                u   = s.t - front;
                pos = u % l;
                if (pos < ha * dv) begin
                    o[3] = 1'b1;
                    o[2] = (pos % dv) == 0;
                    o[1] = m_pix(s.sel, pos / dv, u / l);
                end
            end
        end else if (s.mode == 2) begin
            o[0] = (s.g == 0);
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h required %0h", name, cyc, got, exp);
        end
    endtask

    task automatic clear_stats();
        s_vs_a = 0; s_hrise_a = 0; s_ce_a = 0; s_fd_a = 0; s_dot_a = 0;
        s_dot_idx = -1; s_vrise_a = 0;
        s_ce_b = 0; s_hr_b = 0; s_run_b = 0; s_maxrun_b = 0; s_ne_b = 0; s_fd_b = 0;
        low_run = 0; seen_fall = 1'b0;
        gaps.delete();
    endtask

    // One clock: drive inputs, queue the expected outputs, compare after the edge.
    task automatic step(input logic r, input logic en, input logic [1:0] sl);
        logic [4:0] ga, gb, ea, eb;
        rst = r; enable = en; sel = sl;
        ma = m_next(ma, r, en, sl, 95, 5);
        mb = m_next(mb, r, en, sl, 40, 5);
        q_a.push_back(m_out(ma, 8, 3, 1, 2));
        q_b.push_back(m_out(mb, 8, 0, 1, 1));
        @(posedge clk);
        #1;
        cyc++;
        ga = {a_vs, a_hr, a_ce, a_px, a_fd};
        gb = {b_vs, b_hr, b_ce, b_px, b_fd};
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("A vs/hr/ce/px/fd", 32'(ga), 32'(ea));
        check("B vs/hr/ce/px/fd", 32'(gb), 32'(eb));

        s_vs_a += int'(a_vs);
        if (a_hr && !p_hr_a) s_hrise_a++;
        if (a_ce && a_px) begin
            if (s_dot_a == 0) s_dot_idx = s_ce_a;
            s_dot_a++;
        end
        s_ce_a += int'(a_ce);
        s_fd_a += int'(a_fd);
        if (a_vs && !p_vs_a) begin
            s_vrise_a++;
            if (seen_fall) gaps.push_back(low_run);
        end
        if (!a_vs && p_vs_a) begin
            seen_fall = 1'b1;
            low_run   = 1;
        end else if (!a_vs && seen_fall) begin
            low_run++;
        end
        p_hr_a = a_hr;
        p_vs_a = a_vs;

        s_ce_b += int'(b_ce);
        s_hr_b += int'(b_hr);
        s_fd_b += int'(b_fd);
        if (b_ce != b_hr) s_ne_b++;
        s_run_b = b_hr ? s_run_b + 1 : 0;
        if (s_run_b > s_maxrun_b) s_maxrun_b = s_run_b;
    endtask

    vec_t tbl[10];

    initial begin
        ma = '{0, 0, 0, 2'd0};
        mb = '{0, 0, 0, 2'd0};
        rst = 1'b1; enable = 1'b0; sel = 2'd0;
        clear_stats();

        tbl = '{
            '{1'b1, 1'b0, 2'd0, 3},    // reset
            '{1'b0, 1'b0, 2'd2, 4},    // idle stays quiet
            '{1'b0, 1'b1, 2'd2, 1},    // start a frame ...
            '{1'b0, 1'b0, 2'd2, 30},
            '{1'b1, 1'b0, 2'd2, 3},    // ... abort it with reset mid-frame
            '{1'b0, 1'b0, 2'd2, 2},
            '{1'b0, 1'b1, 2'd2, 1},    // restart, full frame
            '{1'b0, 1'b0, 2'd2, 110},
            '{1'b0, 1'b1, 2'd2, 1},    // checker frame, sel moved to 3 mid-frame
            '{1'b0, 1'b0, 2'd3, 50}
        };
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].en, tbl[i].sl);
        end
        // enable held across the gap: next frame uses stripes, then stop
        for (int k = 0; k < 60; k++) step(1'b0, 1'b1, 2'd3);
        for (int k = 0; k < 120; k++) step(1'b0, 1'b0, 2'd3);

        // Single frame from a one-cycle enable pulse, checker pattern.
        clear_stats();
        step(1'b0, 1'b1, 2'd2);
        for (int k = 0; k < 120; k++) step(1'b0, 1'b0, 2'd2);
        check("A vsync high cycles", 32'(s_vs_a), 32'd95);
        check("A href pulses", 32'(s_hrise_a), 32'd4);
        check("A clken count", 32'(s_ce_a), 32'd32);
        check("A frame_done pulses", 32'(s_fd_a), 32'd1);
        check("A idle vsync", 32'(a_vs), 32'd0);
        check("B clken count", 32'(s_ce_b), 32'd32);
        check("B href cycles", 32'(s_hr_b), 32'd32);
        check("B longest href run", 32'(s_maxrun_b), 32'd32);
        check("B clken!=href cycles", 32'(s_ne_b), 32'd0);
        check("B frame_done pulses", 32'(s_fd_b), 32'd1);

        // Single dot at (3,2): the 4th clken of the 3rd active line.
        clear_stats();
        step(1'b0, 1'b1, 2'd1);
        for (int k = 0; k < 110; k++) step(1'b0, 1'b0, 2'd1);
        check("A dot count", 32'(s_dot_a), 32'd1);
        check("A dot clken index", 32'(s_dot_idx), 32'd19);
        check("A dot-frame clkens", 32'(s_ce_a), 32'd32);

        // enable held: back-to-back frames with a 5-cycle vsync gap.
        clear_stats();
        for (int k = 0; k < 230; k++) step(1'b0, 1'b1, 2'd0);
        for (int k = 0; k < 120; k++) step(1'b0, 1'b0, 2'd0);
        check("A frames with enable held", 32'(s_vrise_a), 32'd3);
        check("A gaps seen", 32'(gaps.size()), 32'd2);
        foreach (gaps[i]) check("A vsync gap length", 32'(gaps[i]), 32'd5);
        check("A frame_done pulses held", 32'(s_fd_a), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
